// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared state/op encodings and default widths for the calculator.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int unsigned C_W_DEFAULT  = 7;
  localparam int unsigned C_RW_DEFAULT = 2 * C_W_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPB  = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/calc_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : calc_shift_add
// Purpose  : Accumulator datapath; one shift-add multiply step or one add per step.
// Revision : 1.0 - initial release
// ============================================================================
module calc_shift_add
  import calc_pkg::*;
#(
  parameter int unsigned W  = C_W_DEFAULT,
  parameter int unsigned RW = C_RW_DEFAULT,
  parameter int unsigned AW = W
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          step,
  input  op_t           op,
  input  logic [AW-1:0] opa,
  input  logic [W-1:0]  opb,
  output logic [RW-1:0] acc,
  output logic          last,
  output logic          ovf_bit
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned XW = RW + W;

  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_acc;
  logic          r_ovf;

  logic [XW-1:0] w_opa_x;
  logic [XW-1:0] w_shifted;
  logic [RW:0]   w_mul_sum;
  logic [RW:0]   w_add_sum;
  logic [RW-1:0] w_acc_next;
  logic          w_step_ovf;

  // Partial product is formed wide so bits shifted past RW can be flagged as lost.
  always_comb begin
    w_opa_x    = XW'(opa);
    w_shifted  = w_opa_x << r_cnt;
    w_mul_sum  = {1'b0, r_acc} + {1'b0, w_shifted[RW-1:0]};
    w_add_sum  = (RW+1)'(opa) + (RW+1)'(opb);
    w_acc_next = r_acc;
    w_step_ovf = 1'b0;
    if (op == OP_MUL) begin
      if (opb[r_cnt]) begin
        w_acc_next = w_mul_sum[RW-1:0];
        w_step_ovf = w_mul_sum[RW] | (|w_shifted[XW-1:RW]);
      end
    end else begin
      w_acc_next = w_add_sum[RW-1:0];
      w_step_ovf = w_add_sum[RW];
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (start) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (step) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      r_ovf <= r_ovf | w_step_ovf;
    end
  end

  assign acc     = r_acc;
  assign ovf_bit = r_ovf;
  assign last    = (op == OP_ADD) || (r_cnt == CW'(W - 1));

endmodule
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer
// Purpose  : Calculator FSM: button edge detect, operand latching, display mux.
//            Define CALC_CHAIN_EN to let a result feed the next operation.
// Revision : 1.0 - initial release
// ============================================================================
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned W  = C_W_DEFAULT,
  parameter int unsigned RW = 2 * W
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic [W-1:0]  bin,
  input  logic          btn0,
  input  logic          btn1,
  input  logic          btn2,
  output logic [RW-1:0] outbin,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

`ifdef CALC_CHAIN_EN
  localparam int unsigned AW = RW;
`else
  localparam int unsigned AW = W;
`endif

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_btn_q;
  logic [2:0]    w_press;
  logic [AW-1:0] r_opa;
  logic [W-1:0]  r_opb;
  op_t           r_op;
  logic          r_done;

  logic          w_load_a;
  logic [AW-1:0] w_opa_next;
  op_t           w_op_next;
  logic          w_start;
  logic [RW-1:0] w_acc;
  logic          w_last;
  logic          w_ovf_bit;
  logic [RW-1:0] w_disp;

  assign w_press = {btn2, btn1, btn0} & ~r_btn_q;

  always_comb begin
    w_state_next = r_state;
    w_load_a     = 1'b0;
    w_opa_next   = AW'(bin);
    w_op_next    = r_op;
    w_start      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_press[1] || w_press[2]) begin
          w_state_next = ST_OPB;
          w_load_a     = 1'b1;
          w_op_next    = w_press[1] ? OP_MUL : OP_ADD;
        end
      end
      ST_OPB: begin
        if (w_press[0]) begin
          w_state_next = ST_EXEC;
          w_start      = 1'b1;
        end
      end
      ST_EXEC: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_press[1] || w_press[2]) begin
`ifdef CALC_CHAIN_EN
          w_state_next = ST_OPB;
          w_load_a     = 1'b1;
          w_opa_next   = w_acc;
          w_op_next    = w_press[1] ? OP_MUL : OP_ADD;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_btn_q <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_op    <= OP_ADD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_btn_q <= {btn2, btn1, btn0};
      r_done  <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
      if (w_load_a) begin
        r_opa <= w_opa_next;
        r_op  <= w_op_next;
      end
      if (w_start) begin
        r_opb <= bin;
      end
    end
  end

  calc_shift_add #(
    .W  (W),
    .RW (RW),
    .AW (AW)
  ) u_shift_add (
    .mclk    (mclk),
    .reset_n (reset_n),
    .start   (w_start),
    .step    (r_state == ST_EXEC),
    .op      (r_op),
    .opa     (r_opa),
    .opb     (r_opb),
    .acc     (w_acc),
    .last    (w_last),
    .ovf_bit (w_ovf_bit)
  );

  // During EXEC the display keeps the last operand that was entered.
  always_comb begin
    w_disp = RW'(bin);
    unique case (r_state)
      ST_EXEC: w_disp = RW'(r_opb);
      ST_DONE: w_disp = w_acc;
      default: w_disp = RW'(bin);
    endcase
  end

  // Display blanks while reset is held, matching the cleared register state.
  assign outbin = reset_n ? w_disp : '0;
  assign busy   = (r_state == ST_EXEC);
  assign done   = r_done;
  assign ovf    = (r_state == ST_DONE) && w_ovf_bit;

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_op_sequencer
// Purpose  : Directed self-checking bench with a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_op_sequencer;

  localparam int W  = 7;
  localparam int RW = 14;
  localparam longint MOD = longint'(1) << RW;

  logic          mclk    = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  bin     = '0;
  logic          btn0    = 1'b0;
  logic          btn1    = 1'b0;
  logic          btn2    = 1'b0;
  logic [RW-1:0] outbin;
  logic          busy;
  logic          done;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  always #5 mclk = ~mclk;

  calc_op_sequencer #(.W(W), .RW(RW)) dut (
    .mclk    (mclk),
    .reset_n (reset_n),
    .bin     (bin),
    .btn0    (btn0),
    .btn1    (btn1),
    .btn2    (btn2),
    .outbin  (outbin),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases are entry-A, entry-B, running, result; results use plain arithmetic.
  int     m_phase = 0;
  longint m_a = 0, m_b = 0, m_res = 0;
  bit     m_mul = 0, m_ovf = 0, m_done = 0;
  int     m_left = 0;
  bit [2:0] m_q = '0;

  always @(posedge mclk or negedge reset_n) begin : model
    bit [2:0] p;
    longint   full;
    if (!reset_n) begin
      m_phase = 0; m_a = 0; m_b = 0; m_res = 0;
      m_mul = 0; m_ovf = 0; m_done = 0; m_left = 0; m_q = '0;
    end else begin
      p      = {btn2, btn1, btn0} & ~m_q;
      m_q    = {btn2, btn1, btn0};
      m_done = 0;
      case (m_phase)
        0: if (p[1] || p[2]) begin
             m_a = bin; m_mul = p[1]; m_phase = 1;
           end
        1: if (p[0]) begin
             m_b     = bin;
             full    = m_mul ? m_a * m_b : m_a + m_b;
             m_res   = full % MOD;
             m_ovf   = (full >= MOD);
             m_left  = m_mul ? W : 1;
             m_phase = 2;
           end
        2: begin
             m_left--;
             if (m_left == 0) begin
               m_phase = 3; m_done = 1;
             end
           end
        default: if (p[1] || p[2]) begin
`ifdef CALC_CHAIN_EN
             m_a = m_res; m_mul = p[1]; m_phase = 1;
`else
             m_phase = 0;
`endif
           end
      endcase
    end
  end

  always @(negedge mclk) begin : compare
    longint exp_out;
    if (!reset_n)          exp_out = 0;
    else if (m_phase == 2) exp_out = m_b;
    else if (m_phase == 3) exp_out = m_res;
    else                   exp_out = longint'(bin);
    chk("cyc outbin", longint'(outbin), exp_out);
    chk("cyc busy",   longint'(busy),   longint'(reset_n && m_phase == 2));
    chk("cyc done",   longint'(done),   longint'(reset_n && m_done));
    chk("cyc ovf",    longint'(ovf),    longint'(reset_n && m_phase == 3 && m_ovf));
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn0 = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
    repeat (2) tick();
    chk("reset outbin", longint'(outbin), 0);
    chk("reset busy",   longint'(busy),   0);
    chk("reset done",   longint'(done),   0);
    chk("reset ovf",    longint'(ovf),    0);
    reset_n = 1'b1;
    tick();
  endtask

  // sel: bit0 -> btn1 (multiply), bit1 -> btn2 (add)
  task automatic launch(input int sel, input logic [W-1:0] a, input logic [W-1:0] b);
    bin  = a;
    btn1 = sel[0];
    btn2 = sel[1];
    tick();
    btn1 = 1'b0; btn2 = 1'b0;
    tick();
    bin  = b;
    btn0 = 1'b1;
    tick();
    btn0 = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int nbusy);
    bit got;
    got   = 0;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (busy) nbusy++;
      tick();
    end
    chk({tag, " done seen"}, longint'(got), 1);
  endtask

  task automatic run_op(input string tag, input int sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input longint exp_out,
                        input int exp_busy, input int exp_ovf);
    int n;
    launch(sel, a, b);
    wait_done(tag, n);
    chk({tag, " result"},      longint'(outbin), exp_out);
    chk({tag, " busy cycles"}, longint'(n),      longint'(exp_busy));
    chk({tag, " ovf"},         longint'(ovf),    longint'(exp_ovf));
    tick();
    chk({tag, " done width"},  longint'(done),   0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    do_reset();
    run_op("mul 12x5", 1, 7'd12, 7'd5, 60, 7, 0);

    do_reset();
    run_op("add 127+127", 2, 7'd127, 7'd127, 254, 1, 0);

    do_reset();
    run_op("mul 127x127", 1, 7'd127, 7'd127, 16129, 7, 0);

    do_reset();
    run_op("priority 3x4", 3, 7'd3, 7'd4, 12, 7, 0);

    // Equals in IDLE is ignored; a held multiply button counts once.
    do_reset();
    bin = 7'd9; btn0 = 1'b1; tick(); btn0 = 1'b0; tick();
    chk("idle eq ignored busy", longint'(busy), 0);
    bin = 7'd5; btn1 = 1'b1;
    repeat (10) tick();
    btn1 = 1'b0; tick();
    bin = 7'd6; btn0 = 1'b1; tick(); btn0 = 1'b0;
    wait_done("held 5x6", n);
    chk("held 5x6 result", longint'(outbin), 30);
    chk("held 5x6 busy",   longint'(n),      7);

    // Asynchronous abort in the third EXEC cycle.
    do_reset();
    launch(1, 7'd12, 7'd5);
    tick(); tick();
    chk("pre-abort busy", longint'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort outbin", longint'(outbin), 0);
    chk("abort busy",   longint'(busy),   0);
    chk("abort done",   longint'(done),   0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("post-abort idle outbin", longint'(outbin), 5);
    chk("post-abort busy",        longint'(busy),   0);

    do_reset();
    run_op("chain base", 1, 7'd127, 7'd127, 16129, 7, 0);
`ifdef CALC_CHAIN_EN
    bin = 7'd2; btn1 = 1'b1; tick(); btn1 = 1'b0; tick();
    bin = 7'd2; btn0 = 1'b1; tick(); btn0 = 1'b0;
    wait_done("chain x2", n);
    chk("chain x2 result", longint'(outbin), 15874);
    chk("chain x2 ovf",    longint'(ovf),    1);
    chk("chain x2 busy",   longint'(n),      7);
    btn2 = 1'b1; tick(); btn2 = 1'b0;
    chk("chain leave ovf", longint'(ovf), 0);
`else
    bin = 7'd2; btn1 = 1'b1; tick(); btn1 = 1'b0;
    chk("no-chain idle outbin", longint'(outbin), 2);
    chk("no-chain idle busy",   longint'(busy),   0);
    tick();
    run_op("no-chain add 10+20", 2, 7'd10, 7'd20, 30, 1, 0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
